// File: rtl/port_requester_if.sv
// port_requester_if: input flit stream, one-hot req/ack handshake and output flit stream of a port requester.
interface port_requester_if #(
  parameter int DATA_W = 32,
  parameter int PORT_W = 5
);
  logic                     in_valid;
  logic [DATA_W-1:0]        in_data;
  logic                     in_last;
  logic                     in_ready;
  logic [(1<<PORT_W)-1:0]   req;
  logic [(1<<PORT_W)-1:0]   ack;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic                     out_last;
  logic                     out_ready;
  modport master (
    input  in_valid, in_data, in_last, ack, out_ready,
    output in_ready, req, out_valid, out_data, out_last
  );
  modport slave (
    output in_valid, in_data, in_last, ack, out_ready,
    input  in_ready, req, out_valid, out_data, out_last
  );
endinterface

// File: rtl/port_requester.sv
// port_requester: decodes a header's route field, requests the matching output port, forwards the stripped packet; optional grant timeout under REQ_TIMEOUT_EN.
module port_requester #(
  parameter int DATA_W  = 32,
  parameter int PORT_W  = 5,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  port_requester_if.master bus,
  output logic             busy,
  output logic             dropped
);
  localparam int N = 1 << PORT_W;
`ifdef REQ_TIMEOUT_EN
  typedef enum logic [2:0] {IDLE, REQ, HDR, BODY, DROP} state_t;
`else
  typedef enum logic [2:0] {IDLE, REQ, HDR, BODY} state_t;
`endif
  state_t              state, state_n;
  logic [DATA_W-1:0]   hdr;
  logic [PORT_W-1:0]   dest, dest_n;
  logic                last_f;
  logic                armed;
  logic                grant;
  // A grant only counts from the second REQ cycle, so a sticky ack from the previous packet is ignored.
  assign grant  = armed && bus.ack[dest];
  assign dest_n = state == IDLE ? bus.in_data[PORT_W-1:0] : dest;
  assign busy   = state != IDLE;
`ifdef REQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT) + 1;
  logic [CW-1:0] cnt;
  logic          expired;
  assign expired = cnt >= CW'(TIMEOUT - 1);
  // Count REQ cycles from zero on every entry, saturating at all-ones.
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= state != REQ ? '0 : (&cnt ? cnt : cnt + 1'b1);
`else
  assign dropped = 1'b0;
`endif
  // State, latched header fields, grant qualifier and the registered one-hot request.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state   <= IDLE;
      hdr     <= '0;
      dest    <= '0;
      last_f  <= 1'b0;
      armed   <= 1'b0;
      bus.req <= '0;
    end else begin
      state   <= state_n;
      armed   <= state == REQ;
      bus.req <= (state_n == REQ || state_n == HDR || state_n == BODY) ? N'(1) << dest_n : '0;
      if (state == IDLE && bus.in_valid) begin
        hdr    <= bus.in_data >> PORT_W;
        dest   <= bus.in_data[PORT_W-1:0];
        last_f <= bus.in_last;
      end
    end
  // Next state and the flit-path outputs for each state.
  always_comb begin
    state_n       = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_last  = 1'b0;
`ifdef REQ_TIMEOUT_EN
    dropped       = 1'b0;
`endif
    case (state)
      IDLE: begin
        bus.in_ready = !reset;
        if (bus.in_valid) state_n = REQ;
      end
      REQ: begin
        if (grant) state_n = HDR;
`ifdef REQ_TIMEOUT_EN
        else if (expired) state_n = DROP;
`endif
      end
      HDR: begin
        bus.out_valid = 1'b1;
        bus.out_data  = hdr;
        bus.out_last  = last_f;
        if (bus.out_ready) state_n = last_f ? IDLE : BODY;
      end
      BODY: begin
        bus.out_valid = bus.in_valid;
        bus.out_data  = bus.in_data;
        bus.out_last  = bus.in_last;
        bus.in_ready  = bus.out_ready;
        if (bus.in_valid && bus.out_ready && bus.in_last) state_n = IDLE;
      end
`ifdef REQ_TIMEOUT_EN
      DROP: begin
        bus.in_ready = !last_f;
        dropped      = last_f || (bus.in_valid && bus.in_last);
        if (last_f || (bus.in_valid && bus.in_last)) state_n = IDLE;
      end
`endif
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_port_requester.sv
// tb_port_requester: vector table for the main packet flows plus hand-written sticky-grant, reset and timeout sequences.
module tb_port_requester;
  logic clk = 1'b0;
  logic reset;
  logic busy, dropped;
  int   checks = 0;
  int   errors = 0;
  int   n, drops, ovs;
  port_requester_if #(.DATA_W(32), .PORT_W(5)) bus ();
  port_requester #(.DATA_W(32), .PORT_W(5), .TIMEOUT(8)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .busy(busy),
    .dropped(dropped)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [2:0]  ctl;
    logic [31:0] d;
    logic [31:0] ack;
    logic [3:0]  ex;
    logic [31:0] req;
    logic [31:0] od;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(logic [2:0] c, logic [31:0] d, logic [31:0] a, logic [3:0] e, logic [31:0] r, logic [31:0] o);
    vec_t v;
    v.ctl = c;
    v.d   = d;
    v.ack = a;
    v.ex  = e;
    v.req = r;
    v.od  = o;
    return v;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    // ctl = {in_valid, in_last, out_ready}; ex = {in_ready, out_valid, out_last, busy}
    tbl.push_back(mk(3'b101, 32'h0000_0123, 32'h0, 4'b1000, 32'h0, 32'h0));
    tbl.push_back(mk(3'b101, 32'hAAAA_0001, 32'h0, 4'b0001, 32'h8, 32'h0));
    tbl.push_back(mk(3'b101, 32'hAAAA_0001, 32'h0, 4'b0001, 32'h8, 32'h0));
    tbl.push_back(mk(3'b101, 32'hAAAA_0001, 32'h8, 4'b0001, 32'h8, 32'h0));
    tbl.push_back(mk(3'b101, 32'hAAAA_0001, 32'h8, 4'b0101, 32'h8, 32'h9));
    tbl.push_back(mk(3'b101, 32'hAAAA_0001, 32'h8, 4'b1101, 32'h8, 32'hAAAA_0001));
    tbl.push_back(mk(3'b111, 32'hBBBB_0002, 32'h8, 4'b1111, 32'h8, 32'hBBBB_0002));
    tbl.push_back(mk(3'b001, 32'h0,         32'h8, 4'b1000, 32'h0, 32'h0));
    tbl.push_back(mk(3'b101, 32'h0000_0043, 32'hFFFF_FFF7, 4'b1000, 32'h0, 32'h0));
    tbl.push_back(mk(3'b101, 32'h1111_1111, 32'hFFFF_FFF7, 4'b0001, 32'h8, 32'h0));
    tbl.push_back(mk(3'b101, 32'h1111_1111, 32'hFFFF_FFF7, 4'b0001, 32'h8, 32'h0));
    tbl.push_back(mk(3'b101, 32'h1111_1111, 32'hFFFF_FFF7, 4'b0001, 32'h8, 32'h0));
    tbl.push_back(mk(3'b101, 32'h1111_1111, 32'hFFFF_FFFF, 4'b0001, 32'h8, 32'h0));
    tbl.push_back(mk(3'b100, 32'h1111_1111, 32'h0, 4'b0101, 32'h8, 32'h2));
    tbl.push_back(mk(3'b101, 32'h1111_1111, 32'h0, 4'b0101, 32'h8, 32'h2));
    tbl.push_back(mk(3'b100, 32'h1111_1111, 32'h0, 4'b0101, 32'h8, 32'h1111_1111));
    tbl.push_back(mk(3'b101, 32'h1111_1111, 32'h0, 4'b1101, 32'h8, 32'h1111_1111));
    tbl.push_back(mk(3'b100, 32'h2222_2222, 32'h0, 4'b0101, 32'h8, 32'h2222_2222));
    tbl.push_back(mk(3'b101, 32'h2222_2222, 32'h0, 4'b1101, 32'h8, 32'h2222_2222));
    tbl.push_back(mk(3'b001, 32'h3333_3333, 32'h0, 4'b1001, 32'h8, 32'h3333_3333));
    tbl.push_back(mk(3'b110, 32'h3333_3333, 32'h0, 4'b0111, 32'h8, 32'h3333_3333));
    tbl.push_back(mk(3'b111, 32'h3333_3333, 32'h0, 4'b1111, 32'h8, 32'h3333_3333));
    tbl.push_back(mk(3'b001, 32'h0,         32'h0, 4'b1000, 32'h0, 32'h0));
    tbl.push_back(mk(3'b111, 32'hABCD_001F, 32'h0, 4'b1000, 32'h0, 32'h0));
    tbl.push_back(mk(3'b001, 32'h0, 32'h8000_0000, 4'b0001, 32'h8000_0000, 32'h0));
    tbl.push_back(mk(3'b001, 32'h0, 32'h8000_0000, 4'b0001, 32'h8000_0000, 32'h0));
    tbl.push_back(mk(3'b001, 32'h0, 32'h8000_0000, 4'b0111, 32'h8000_0000, 32'h055E_6800));
    tbl.push_back(mk(3'b001, 32'h0, 32'h0,         4'b1000, 32'h0, 32'h0));
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    bus.ack = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_req", bus.req, 32'h0);
    chk("reset_ctl", {27'd0, bus.in_ready, bus.out_valid, bus.out_last, busy, dropped}, 32'h0);
    chk("reset_data", bus.out_data, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    foreach (tbl[i]) begin
      @(negedge clk);
      {bus.in_valid, bus.in_last, bus.out_ready} = tbl[i].ctl;
      bus.in_data = tbl[i].d;
      bus.ack = tbl[i].ack;
      #1;
      checks++;
      if ({bus.in_ready, bus.out_valid, bus.out_last, busy} !== tbl[i].ex || bus.req !== tbl[i].req ||
          bus.out_data !== tbl[i].od || dropped !== 1'b0) begin
        errors++;
        $display("FAIL vec%0d: rdy/ov/ol/busy=%b req=%h data=%h dropped=%b expected %b %h %h 0",
                 i, {bus.in_ready, bus.out_valid, bus.out_last, busy}, bus.req, bus.out_data, dropped,
                 tbl[i].ex, tbl[i].req, tbl[i].od);
      end
    end
    bus.ack = 32'h20;
    bus.out_ready = 1'b1;
    for (int p = 0; p < 2; p++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data = ((p + 1) << 5) | 5;
      bus.in_last = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      chk("sticky_req", bus.req, 32'h20);
      n = 0;
      while (!bus.out_valid && n < 10) begin
        @(negedge clk);
        #1;
        n++;
      end
      chk("sticky_latency", n, 2);
      chk("sticky_hdr", bus.out_data, p + 1);
    end
    bus.ack = '0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data = 32'h129;
    bus.in_last = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk("midreset_req_before", bus.req, 32'h200);
    #2;
    reset = 1'b1;
    #1;
    chk("midreset_req", bus.req, 32'h0);
    chk("midreset_ctl", {27'd0, bus.in_ready, bus.out_valid, bus.out_last, busy, dropped}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("after_reset_idle", {30'd0, bus.in_ready, busy}, 32'h2);
`ifdef REQ_TIMEOUT_EN
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data = 32'h47;
    bus.in_last = 1'b0;
    @(negedge clk);
    bus.in_data = 32'hD000_0001;
    #1;
    n = 0;
    while (bus.req != 0 && n < 20) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk("timeout_req_cycles", n, 8);
    drops = 0;
    ovs = 0;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = 32'hD000_0001 + i;
      bus.in_last = (i == 2);
      #1;
      chk("drop_in_ready", {31'd0, bus.in_ready}, 32'h1);
      drops += int'(dropped);
      ovs += int'(bus.out_valid);
      @(negedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    repeat (2) begin
      #1;
      drops += int'(dropped);
      ovs += int'(bus.out_valid);
      @(negedge clk);
    end
    chk("drop_pulses", drops, 1);
    chk("drop_no_output", ovs, 0);
    chk("drop_idle", {31'd0, busy}, 32'h0);
    bus.ack = 32'h4;
    bus.in_valid = 1'b1;
    bus.in_data = 32'h62;
    bus.in_last = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("post_drop_latency", n, 2);
    chk("post_drop_hdr", bus.out_data, 32'h3);
    chk("post_drop_last", {31'd0, bus.out_last}, 32'h1);
`endif
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/port_requester.md
# port_requester

Per-input-port requester for the source-routed switch: the requesting end of the 32-way round-robin output arbiter's one-hot req/ack handshake. It accepts a packet header from the input port, decodes the destination output port from the route field, and raises the matching request line. It waits for the grant, then forwards the packet with the consumed route field stripped, and releases the request after the tail flit.

## Interface

**Parameters**
- `DATA_W`, default 32: flit width; must be at least `PORT_W`+1.
- `PORT_W`, default 5: route field width per hop; there are 2^`PORT_W` = 32 output ports.
- `TIMEOUT`, default 64: cycles to wait for a grant before dropping the packet. Used only when `REQ_TIMEOUT_EN` is defined.

**Ports**
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: input flit valid.
- `in_data` in `DATA_W`: input flit. First flit of a packet is the header.
- `in_last` in 1: marks the tail flit.
- `in_ready` out 1: input flit accepted when `in_valid && in_ready`.
- `req` out 32: one-hot request to the output arbiters; registered.
- `ack` in 32: one-hot grant from the arbiters; may be sticky.
- `out_valid` out 1: output flit valid.
- `out_data` out `DATA_W`: output flit.
- `out_last` out 1: tail marker.
- `out_ready` in 1: downstream ready.
- `busy` out 1: high in any state other than IDLE.
- `dropped` out 1: one-cycle pulse when a packet is discarded on timeout.

## Operation

**Header handling**
- Destination `dest` = `in_data[PORT_W-1:0]` of the header.
- Forwarded header = `in_data >> PORT_W`, logical shift, upper bits zero-filled.
- The header's `in_last` is captured with it, so single-flit packets are legal.

**State machine**
- IDLE
  - `in_ready`=1.
  - On header accept: latch the shifted header, `dest` and the last flag; go to REQ.
- REQ
  - `in_ready`=0; `req` = 1<<`dest`.
  - A grant is `ack[dest]`=1, sampled from the second REQ cycle onward. This filters a sticky ack left over from an earlier grant. All other `ack` bits are ignored.
  - On grant, go to HDR.
- HDR
  - `out_valid`=1, `out_data` = latched header, `out_last` = latched last flag; `in_ready`=0.
  - On `out_ready`: if the last flag is set, go to IDLE; otherwise go to BODY.
- BODY
  - Pass-through: `out_valid`=`in_valid`, `out_data`=`in_data`, `out_last`=`in_last`, `in_ready`=`out_ready`.
  - On an accepted flit with `in_last`, go to IDLE.
- DROP (`REQ_TIMEOUT_EN` only)
  - `req`=0, `out_valid`=0, `in_ready`=1; discard flits.
  - On an accepted `in_last`, pulse `dropped` and go to IDLE.
  - If the header itself carried last, pulse `dropped` on entry to DROP and go to IDLE.

**Request and counter rules**
- `req` holds steady from REQ through the tail handshake. It clears on the cycle after the tail is accepted.
- `req` is never multi-hot.
- The wait counter is `$clog2(TIMEOUT)+1` bits, cleared on entry to REQ, and saturating.

## Timing

- **Reset values:** `req`=0, `out_valid`=0, `out_last`=0, `out_data`=0, `in_ready`=0 while `reset` is high, `busy`=0, `dropped`=0. State is IDLE.
- **Header to request:** header accepted at edge t, `req` high from t+1.
- **Grant to header out:** `ack[dest]` sampled high at edge k (k ≥ t+2), `out_valid` with the header from k+1.
- **Body latency:** combinational, zero cycles.
- **Tail to release:** tail accepted at edge m, `req`=0 and IDLE from m+1. The next header can be accepted at m+1.
- **Back-to-back to the same dest:** the grant is requalified per the second-cycle rule.
- **Reset mid-packet:** everything returns to reset values immediately. The partial packet is abandoned; no `dropped` pulse.

## Configuration

- `REQ_TIMEOUT_EN` defined:
  - If no grant arrives by cycle `TIMEOUT` of REQ, `req` is deasserted and the state goes to DROP.
  - The rest of the packet is flushed and `dropped` pulses once.
- `REQ_TIMEOUT_EN` undefined:
  - REQ waits indefinitely; no counter and no DROP state.
  - `dropped` is tied to 0.

## Test plan

- Header `0x0000_0123` (dest 3) + 2 body flits, `ack[3]` returned 2 cycles after `req` → `req`=`0x8` for the whole packet; out header `0x0000_0009`; body unchanged; `req`=0 the cycle after the tail.
- Single-flit packet, dest 31 → `req`=`0x8000_0000`; one output flit with `out_last`=1; back to IDLE.
- `ack` = `0xFFFF_FFF7` while dest=3 → no grant and no output; grant only when `ack[3]`=1.
- Sticky `ack[5]` held high, two consecutive packets to dest 5 → second header forwarded no earlier than 2 cycles after the second `req` rise.
- `out_ready` toggling 1/0 during BODY → no flit lost or duplicated; `in_ready` mirrors `out_ready`.
- `REQ_TIMEOUT_EN`, `TIMEOUT`=8, `ack`=0 → `req` falls after 8 REQ cycles; 4-flit packet flushed; `dropped` pulses once; next packet served normally.
